// File: rtl/antirrebote_multicanal_if.sv
// Pin-side bundle of the multichannel debouncer: raw inputs in, clean levels and pulses out.
interface antirrebote_multicanal_if #(
    parameter int unsigned N_CANALES = 4
);
    logic [N_CANALES-1:0] senal_entrada;
    logic [N_CANALES-1:0] salida_limpia;
    logic [N_CANALES-1:0] flanco_subida;
    logic [N_CANALES-1:0] flanco_bajada;
    logic [N_CANALES-1:0] pulsacion_larga;

    modport master (
        output senal_entrada,
        input  salida_limpia,
        input  flanco_subida,
        input  flanco_bajada,
        input  pulsacion_larga
    );

    modport slave (
        input  senal_entrada,
        output salida_limpia,
        output flanco_subida,
        output flanco_bajada,
        output pulsacion_larga
    );
endinterface

// File: rtl/antirrebote_multicanal.sv
// N-channel push-button debouncer: 2-FF synchroniser, stability counter, edge pulses and
// a once-per-press long-hold pulse per channel.
module antirrebote_multicanal #(
    parameter int unsigned         N_CANALES      = 4,
    parameter int unsigned         CICLOS_ESTABLE = 5,
    parameter int unsigned         CICLOS_LARGO   = 1000,
    parameter logic [N_CANALES-1:0] ACTIVO_BAJO   = '0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    antirrebote_multicanal_if.slave  bus
);

    localparam int unsigned CNT_W = $clog2(CICLOS_ESTABLE + 1);
    localparam logic [CNT_W-1:0] CNT_ULT = CNT_W'(CICLOS_ESTABLE - 1);

    logic [N_CANALES-1:0] s1_q, s1_d;
    logic [N_CANALES-1:0] s2_q, s2_d;
    logic [N_CANALES-1:0] limpia_q, limpia_d;
    logic [N_CANALES-1:0] subida_q, subida_d;
    logic [N_CANALES-1:0] bajada_q, bajada_d;
    logic [N_CANALES-1:0] larga_q;
    logic [CNT_W-1:0]     cnt_q [N_CANALES];
    logic [CNT_W-1:0]     cnt_d [N_CANALES];

    // Synchroniser, stability counter and edge detection for every channel
    always_comb begin
        s1_d     = bus.senal_entrada ^ ACTIVO_BAJO;
        s2_d     = s1_q;
        limpia_d = limpia_q;
        for (int i = 0; i < int'(N_CANALES); i++) begin
            cnt_d[i] = '0;
            if (s2_q[i] != limpia_q[i]) begin
                if (cnt_q[i] == CNT_ULT) begin
                    limpia_d[i] = s2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
        subida_d = limpia_d & ~limpia_q;
        bajada_d = ~limpia_d & limpia_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q     <= '0;
            s2_q     <= '0;
            limpia_q <= '0;
            subida_q <= '0;
            bajada_q <= '0;
            for (int i = 0; i < int'(N_CANALES); i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            s1_q     <= s1_d;
            s2_q     <= s2_d;
            limpia_q <= limpia_d;
            subida_q <= subida_d;
            bajada_q <= bajada_d;
            for (int i = 0; i < int'(N_CANALES); i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    generate
        if (CICLOS_LARGO > 0) begin : g_larga
            localparam int unsigned HC_W = $clog2(CICLOS_LARGO + 1);
            localparam logic [HC_W-1:0] HC_MAX = HC_W'(CICLOS_LARGO);

            logic [HC_W-1:0]      hc_q [N_CANALES];
            logic [HC_W-1:0]      hc_d [N_CANALES];
            logic [N_CANALES-1:0] larga_d;

            // Saturating hold counter; cleared whenever the clean level is or becomes 0
            always_comb begin
                larga_d = '0;
                for (int i = 0; i < int'(N_CANALES); i++) begin
                    hc_d[i] = hc_q[i];
                    if (!limpia_q[i] || !limpia_d[i]) begin
                        hc_d[i] = '0;
                    end else if (hc_q[i] != HC_MAX) begin
                        hc_d[i]    = hc_q[i] + HC_W'(1);
                        larga_d[i] = (hc_q[i] == HC_MAX - HC_W'(1));
                    end
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    larga_q <= '0;
                    for (int i = 0; i < int'(N_CANALES); i++) begin
                        hc_q[i] <= '0;
                    end
                end else begin
                    larga_q <= larga_d;
                    for (int i = 0; i < int'(N_CANALES); i++) begin
                        hc_q[i] <= hc_d[i];
                    end
                end
            end
        end else begin : g_sin_larga
            assign larga_q = '0;
        end
    endgenerate

    assign bus.salida_limpia   = limpia_q;
    assign bus.flanco_subida   = subida_q;
    assign bus.flanco_bajada   = bajada_q;
    assign bus.pulsacion_larga = larga_q;

endmodule

// File: tb/tb_antirrebote_multicanal.sv
// Bench for antirrebote_multicanal: directed scenarios plus random bouncing, checked every
// cycle against a sample-history reference model.
module tb_antirrebote_multicanal;

    localparam int unsigned N      = 4;
    localparam int unsigned ESTAB  = 5;
    localparam int unsigned LARGO  = 20;
    localparam logic [N-1:0] MASK  = 4'b1000;

    logic clk;
    logic rst_n;
    logic [N-1:0] pins;

    int checks;
    int errors;

    antirrebote_multicanal_if #(.N_CANALES(N)) bus ();

    assign bus.senal_entrada = pins;

    antirrebote_multicanal #(
        .N_CANALES      (N),
        .CICLOS_ESTABLE (ESTAB),
        .CICLOS_LARGO   (LARGO),
        .ACTIVO_BAJO    (MASK)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: xh[c][k] is the logical pin value sampled k edges ago.
    // The clean level flips when the synchronised samples (2..6 edges old) all disagree with it.
    logic [6:0]   xh     [N];
    logic [N-1:0] m_out;
    logic [N-1:0] m_rise;
    logic [N-1:0] m_fall;
    logic [N-1:0] m_long;
    int           m_age  [N];

    task automatic model_reset();
        for (int c = 0; c < int'(N); c++) begin
            xh[c]    = '0;
            m_age[c] = 0;
        end
        m_out  = '0;
        m_rise = '0;
        m_fall = '0;
        m_long = '0;
    endtask

    task automatic model_edge();
        logic mis;
        logic nuevo;
        if (!rst_n) begin
            model_reset();
        end else begin
            for (int c = 0; c < int'(N); c++) begin
                xh[c] = {xh[c][5:0], pins[c] ^ MASK[c]};
                mis = 1'b1;
                for (int k = 2; k <= 6; k++) begin
                    if (xh[c][k] == m_out[c]) mis = 1'b0;
                end
                nuevo     = mis ? ~m_out[c] : m_out[c];
                m_rise[c] = !m_out[c] && nuevo;
                m_fall[c] = m_out[c] && !nuevo;
                if (m_out[c] && nuevo) m_age[c] = m_age[c] + 1;
                else                   m_age[c] = 0;
                m_long[c] = (m_age[c] == int'(LARGO));
                m_out[c]  = nuevo;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        chk("limpia", 32'(bus.salida_limpia),   32'(m_out));
        chk("subida", 32'(bus.flanco_subida),   32'(m_rise));
        chk("bajada", 32'(bus.flanco_bajada),   32'(m_fall));
        chk("larga",  32'(bus.pulsacion_larga), 32'(m_long));
    endtask

    initial begin
        int n_larga;
        logic [5:0] rebote;
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        pins   = MASK;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("reset_limpia", 32'(bus.salida_limpia),   32'd0);
        chk("reset_pulsos", 32'({bus.flanco_subida, bus.flanco_bajada, bus.pulsacion_larga}), 32'd0);
        rst_n = 1'b1;

        // Idle: all logical inputs inactive
        repeat (50) step();
        chk("idle_limpia", 32'(bus.salida_limpia), 32'd0);

        // ch0 single clean step
        pins[0] = 1'b1;
        repeat (6) step();
        chk("ch0_antes", 32'(bus.salida_limpia[0]), 32'd0);
        step();
        chk("ch0_sube",   32'(bus.salida_limpia[0]), 32'd1);
        chk("ch0_pulso",  32'(bus.flanco_subida[0]), 32'd1);
        chk("ch0_otros",  32'(bus.salida_limpia[3:1]), 32'd0);
        step();
        chk("ch0_pulso_fin", 32'(bus.flanco_subida[0]), 32'd0);

        // ch1 bounce 1,0,1,1,0,1 then steady
        rebote = 6'b101101;
        for (int k = 5; k >= 0; k--) begin
            pins[1] = rebote[k];
            step();
            chk("ch1_rebote", 32'(bus.salida_limpia[1]), 32'd0);
        end
        repeat (5) step();
        chk("ch1_antes", 32'(bus.salida_limpia[1]), 32'd0);
        step();
        chk("ch1_sube", 32'(bus.salida_limpia[1]), 32'd1);

        // ch2 long hold, release, then a short press
        pins[2] = 1'b1;
        repeat (6) step();
        chk("ch2_antes", 32'(bus.salida_limpia[2]), 32'd0);
        step();
        chk("ch2_subida", 32'(bus.flanco_subida[2]), 32'd1);
        for (int k = 1; k <= int'(LARGO); k++) begin
            step();
            chk("ch2_larga_t", 32'(bus.pulsacion_larga[2]), (k == int'(LARGO)) ? 32'd1 : 32'd0);
        end
        n_larga = 0;
        repeat (20) begin
            step();
            n_larga += int'(bus.pulsacion_larga[2]);
        end
        chk("ch2_una_larga", 32'(n_larga), 32'd0);
        pins[2] = 1'b0;
        repeat (6) step();
        step();
        chk("ch2_bajada", 32'(bus.flanco_bajada[2]), 32'd1);
        n_larga = 0;
        pins[2] = 1'b1;
        repeat (10) begin
            step();
            n_larga += int'(bus.pulsacion_larga[2]);
        end
        pins[2] = 1'b0;
        repeat (30) begin
            step();
            n_larga += int'(bus.pulsacion_larga[2]);
        end
        chk("ch2_corta", 32'(n_larga), 32'd0);

        // ch3 active-low
        chk("ch3_inactivo", 32'(bus.salida_limpia[3]), 32'd0);
        pins[3] = 1'b0;
        repeat (6) step();
        chk("ch3_antes", 32'(bus.salida_limpia[3]), 32'd0);
        step();
        chk("ch3_sube", 32'(bus.salida_limpia[3]), 32'd1);

        // Async reset mid-count (ch2) and mid-hold (ch3)
        pins[2] = 1'b1;
        repeat (4) step();
        rst_n = 1'b0;
        #1;
        chk("rst_async_limpia", 32'(bus.salida_limpia), 32'd0);
        chk("rst_async_pulsos", 32'({bus.flanco_subida, bus.flanco_bajada, bus.pulsacion_larga}), 32'd0);
        repeat (2) step();
        rst_n = 1'b1;
        repeat (6) begin
            step();
            chk("rst_sin_pulsos", 32'({bus.flanco_subida, bus.flanco_bajada, bus.pulsacion_larga}), 32'd0);
        end
        repeat (30) step();

        // Random bouncing, then random long presses
        for (int k = 0; k < 1500; k++) begin
            for (int c = 0; c < int'(N); c++) begin
                if ($urandom_range(15) == 0) pins[c] = ~pins[c];
            end
            step();
        end
        for (int k = 0; k < 1500; k++) begin
            for (int c = 0; c < int'(N); c++) begin
                if ($urandom_range(59) == 0) pins[c] = ~pins[c];
            end
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
